// File: rtl/data_cache_controller.sv
// Lookup-and-refill controller for a direct-mapped, one-word-per-line data cache.
// Loads refill on miss; stores are write-through with no-write-allocate.
module data_cache_controller #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int SET_WIDTH     = 3,
    parameter int TAG_WIDTH     = 27
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    input  logic                     req_we,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    output logic                     stall,
    output logic                     resp_valid,
    output logic [DATA_WIDTH-1:0]    resp_rdata,
    output logic [SET_WIDTH-1:0]     c_set,
    input  logic                     c_V,
    input  logic [TAG_WIDTH-1:0]     c_tag,
    input  logic [DATA_WIDTH-1:0]    c_data,
    output logic                     c_we,
    output logic [SET_WIDTH-1:0]     c_wset,
    output logic                     c_wV,
    output logic [TAG_WIDTH-1:0]     c_wtag,
    output logic [DATA_WIDTH-1:0]    c_wdata,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    input  logic                     mem_ack,
    input  logic [DATA_WIDTH-1:0]    mem_rdata
);

    typedef enum logic [2:0] {INIT, IDLE, LOOKUP, MEM_RD, MEM_WR} state_t;

    state_t                     state;
    logic [SET_WIDTH-1:0]       init_cnt;
    logic [ADDRESS_WIDTH-3:0]   word_addr_q;
    logic [DATA_WIDTH-1:0]      wdata_q;
    logic                       we_q;

    // Byte offset is ignored: all accesses are whole words.
    wire unused_offset = ^req_addr[1:0];

    wire [SET_WIDTH-1:0] set_q = word_addr_q[SET_WIDTH-1:0];
    wire [TAG_WIDTH-1:0] tag_q = word_addr_q[ADDRESS_WIDTH-3:SET_WIDTH];
    wire                 hit   = c_V && (c_tag == tag_q);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= INIT;
            init_cnt    <= '0;
            word_addr_q <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    init_cnt <= init_cnt + 1'b1;
                    if (&init_cnt) state <= IDLE;
                end
                IDLE: begin
                    if (req_valid) begin
                        word_addr_q <= req_addr[ADDRESS_WIDTH-1:2];
                        wdata_q     <= req_wdata;
                        we_q        <= req_we;
                        state       <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (we_q)     state <= MEM_WR;
                    else if (hit) state <= IDLE;
                    else          state <= MEM_RD;
                end
                MEM_RD, MEM_WR: begin
                    if (mem_ack) state <= IDLE;
                end
                default: state <= INIT;
            endcase
        end
    end

    // NOTE: every output gets a default before the case, so no path through
    // this block leaves a signal unassigned and no latch is inferred.
    always_comb begin
        stall      = rst || (state != IDLE);
        resp_valid = 1'b0;
        resp_rdata = '0;
        c_set      = (state == IDLE) ? req_addr[SET_WIDTH+1:2] : set_q;
        c_we       = 1'b0;
        c_wset     = set_q;
        c_wV       = 1'b0;
        c_wtag     = tag_q;
        c_wdata    = wdata_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = {word_addr_q, 2'b00};
        mem_wdata  = wdata_q;

        // While rst is asserted nothing is strobed; the sweep starts after release.
        if (!rst) begin
            case (state)
                INIT: begin
                    c_we   = 1'b1;
                    c_wset = init_cnt;
                end
                LOOKUP: begin
                    if (hit && !we_q) begin
                        resp_valid = 1'b1;
                        resp_rdata = c_data;
                    end else if (hit && we_q) begin
                        c_we = 1'b1;
                        c_wV = 1'b1;
                    end
                end
                MEM_RD: begin
                    mem_req = 1'b1;
                    if (mem_ack) begin
                        c_we       = 1'b1;
                        c_wV       = 1'b1;
                        c_wdata    = mem_rdata;
                        resp_valid = 1'b1;
                        resp_rdata = mem_rdata;
                    end
                end
                MEM_WR: begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                    if (mem_ack) resp_valid = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_data_cache_controller.sv
// Directed bench for data_cache_controller with a registered-read storage array model
// and a hand-driven memory handshake.
module tb_data_cache_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_we;
    logic [31:0] req_addr, req_wdata;
    logic        stall, resp_valid;
    logic [31:0] resp_rdata;
    logic [2:0]  c_set, c_wset;
    logic        c_V, c_we, c_wV;
    logic [26:0] c_tag, c_wtag;
    logic [31:0] c_data, c_wdata;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    data_cache_controller dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .c_set(c_set), .c_V(c_V), .c_tag(c_tag), .c_data(c_data),
        .c_we(c_we), .c_wset(c_wset), .c_wV(c_wV), .c_wtag(c_wtag), .c_wdata(c_wdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    // Storage array: no reset, starts with stale valid lines (tag 1 everywhere).
    logic        st_v [8] = '{default: 1'b1};
    logic [26:0] st_t [8] = '{default: 27'd1};
    logic [31:0] st_d [8] = '{default: 32'hBAD0_BAD0};

    always @(posedge clk) begin
        if (c_we) begin
            st_v[c_wset] <= c_wV;
            st_t[c_wset] <= c_wtag;
            st_d[c_wset] <= c_wdata;
        end
        c_V    <= st_v[c_set];
        c_tag  <= st_t[c_set];
        c_data <= st_d[c_set];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Present a request in IDLE and advance into LOOKUP.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        settle();
        check("idle_stall", 32'(stall), 32'd0);
        check("idle_c_set", 32'(c_set), 32'(addr[4:2]));
        tick();
        req_valid = 1'b0;
        settle();
        check("lookup_stall", 32'(stall), 32'd1);
    endtask

    // From LOOKUP: step into the memory state, wait, then ack.
    task automatic mem_phase(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input int waits, input logic [31:0] rdata, input logic [31:0] exp_resp);
        tick();
        for (int i = 0; i <= waits; i++) begin
            check("mem_req", 32'(mem_req), 32'd1);
            check("mem_we", 32'(mem_we), 32'(we));
            check("mem_addr", mem_addr, {addr[31:2], 2'b00});
            if (we) check("mem_wdata", mem_wdata, wdata);
            check("wait_resp", 32'(resp_valid), 32'd0);
            check("wait_c_we", 32'(c_we), 32'd0);
            if (i < waits) tick();
        end
        mem_ack   = 1'b1;
        mem_rdata = rdata;
        settle();
        check("ack_resp_valid", 32'(resp_valid), 32'd1);
        check("ack_resp_rdata", resp_rdata, exp_resp);
        check("ack_c_we", 32'(c_we), 32'(!we));
        if (!we) begin
            check("fill_set", 32'(c_wset), 32'(addr[4:2]));
            check("fill_tag", 32'(c_wtag), addr >> 5);
            check("fill_v", 32'(c_wV), 32'd1);
            check("fill_data", c_wdata, rdata);
        end
        tick();
        mem_ack = 1'b0;
        settle();
        check("post_ack_req", 32'(mem_req), 32'd0);
        check("post_ack_resp", 32'(resp_valid), 32'd0);
        check("post_ack_stall", 32'(stall), 32'd0);
    endtask

    task automatic load_hit(input logic [31:0] addr, input logic [31:0] exp);
        issue(1'b0, addr, 32'd0);
        check("hit_resp_valid", 32'(resp_valid), 32'd1);
        check("hit_resp_rdata", resp_rdata, exp);
        check("hit_mem_req", 32'(mem_req), 32'd0);
        tick();
        check("hit_back_idle", 32'(stall), 32'd0);
        check("hit_no_req", 32'(mem_req), 32'd0);
    endtask

    task automatic init_sweep();
        for (int i = 0; i < 8; i++) begin
            check("init_c_we", 32'(c_we), 32'd1);
            check("init_c_wset", 32'(c_wset), 32'(i));
            check("init_c_wV", 32'(c_wV), 32'd0);
            check("init_stall", 32'(stall), 32'd1);
            check("init_resp", 32'(resp_valid), 32'd0);
            check("init_mem_req", 32'(mem_req), 32'd0);
            tick();
        end
        check("init_done_stall", 32'(stall), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;

        // Reset state
        tick();
        check("rst_stall", 32'(stall), 32'd1);
        check("rst_c_we", 32'(c_we), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_resp", 32'(resp_valid), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_c_wset", 32'(c_wset), 32'd0);
        rst = 1'b0;
        settle();
        init_sweep();

        // Load miss at 0x24 (set 1, tag 1) despite stale line, then hit
        issue(1'b0, 32'h0000_0024, 32'd0);
        check("miss24_resp", 32'(resp_valid), 32'd0);
        mem_phase(1'b0, 32'h0000_0024, 32'd0, 3, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        load_hit(32'h0000_0024, 32'hDEAD_BEEF);

        // Stray ack in IDLE is ignored
        mem_ack = 1'b1;
        settle();
        check("stray_ack_resp", 32'(resp_valid), 32'd0);
        check("stray_ack_c_we", 32'(c_we), 32'd0);
        tick();
        mem_ack = 1'b0;
        settle();
        check("stray_ack_idle", 32'(stall), 32'd0);

        // Conflict: 0x44 evicts set 1, then 0x26 (offset ignored) misses again
        issue(1'b0, 32'h0000_0044, 32'd0);
        check("miss44_resp", 32'(resp_valid), 32'd0);
        mem_phase(1'b0, 32'h0000_0044, 32'd0, 1, 32'hCAFE_F00D, 32'hCAFE_F00D);
        issue(1'b0, 32'h0000_0026, 32'd0);
        check("remiss24_resp", 32'(resp_valid), 32'd0);
        mem_phase(1'b0, 32'h0000_0024, 32'd0, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

        // Store hit: storage updated in LOOKUP, then write-through
        issue(1'b1, 32'h0000_0024, 32'h1234_5678);
        check("sthit_c_we", 32'(c_we), 32'd1);
        check("sthit_c_wset", 32'(c_wset), 32'd1);
        check("sthit_c_wtag", 32'(c_wtag), 32'd1);
        check("sthit_c_wV", 32'(c_wV), 32'd1);
        check("sthit_c_wdata", c_wdata, 32'h1234_5678);
        check("sthit_resp", 32'(resp_valid), 32'd0);
        mem_phase(1'b1, 32'h0000_0024, 32'h1234_5678, 1, 32'hFFFF_FFFF, 32'd0);
        load_hit(32'h0000_0024, 32'h1234_5678);

        // Store miss: no allocate, so the following load misses
        issue(1'b1, 32'h0000_0064, 32'hA5A5_A5A5);
        check("stmiss_c_we", 32'(c_we), 32'd0);
        mem_phase(1'b1, 32'h0000_0064, 32'hA5A5_A5A5, 2, 32'h0, 32'd0);
        issue(1'b0, 32'h0000_0064, 32'd0);
        check("miss64_resp", 32'(resp_valid), 32'd0);
        mem_phase(1'b0, 32'h0000_0064, 32'd0, 0, 32'h0BAD_CAFE, 32'h0BAD_CAFE);

        // Reset during MEM_RD with ack withheld; late ack during sweep ignored
        issue(1'b0, 32'h0000_0104, 32'd0);
        tick();
        check("pre_rst_mem_req", 32'(mem_req), 32'd1);
        rst = 1'b1;
        tick();
        check("midrst_mem_req", 32'(mem_req), 32'd0);
        check("midrst_resp", 32'(resp_valid), 32'd0);
        check("midrst_c_we", 32'(c_we), 32'd0);
        check("midrst_stall", 32'(stall), 32'd1);
        rst       = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'h5555_5555;
        settle();
        init_sweep();
        mem_ack = 1'b0;
        settle();

        // Sweep cleared the line filled earlier
        issue(1'b0, 32'h0000_0064, 32'd0);
        check("post_rst_miss", 32'(resp_valid), 32'd0);
        mem_phase(1'b0, 32'h0000_0064, 32'd0, 0, 32'h7777_0000, 32'h7777_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
